fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end that generates the fetch PC, issues synchronous-read requests to instruction memory, steers fetch with external BTB/gshare predictions, and buffers fetched instructions with their prediction metadata in a DEPTH-entry queue. The queue decouples fetch from decode, which pulls entries through a valid/ready handshake. The block sits between the PC-select/BTB/predictor logic and the decode stage. It replaces the single-register fetch boundary with back-pressure, stale-response squashing on redirect, and configurable depth.

---
 rtl/fetch_queue_unit.sv | 198 +++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC generation, predicted steering, and a queue of fetched entries.
// Latency: request in cycle t, data captured at the end of t+1, entry visible at the head in t+2.
// Backpressure: a new request issues only while queued entries plus the in-flight response fit in DEPTH.
//
// Ports:
//   clk, resetN          clock (rising edge) and asynchronous active-low reset
//   flush, flushPC       backend redirect; has priority over everything else
//   freeze               blocks new fetch issue only
//   imemReq, imemAddr    fetch request and address (address is the PC register; also drives BTB/PHT lookup)
//   imemData             instruction returned the cycle after imemReq
//   btbHit, btbTarget    BTB lookup result for imemAddr
//   phtState, ghrIndex   gshare counter and index for imemAddr
//   outValid, outReady   head-of-queue handshake towards decode
//   outInstr, outPC, outPredPC, outPredTaken, outGHRIndex, outPHTState   head entry contents
//   count                queue occupancy
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              INDEX    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        flush,
  input  logic [XLEN-1:0]             flushPC,
  input  logic                        freeze,
  output logic                        imemReq,
  output logic [XLEN-1:0]             imemAddr,
  input  logic [XLEN-1:0]             imemData,
  input  logic                        btbHit,
  input  logic [XLEN-1:0]             btbTarget,
  input  logic [1:0]                  phtState,
  input  logic [INDEX-1:0]            ghrIndex,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [XLEN-1:0]             outInstr,
  output logic [XLEN-1:0]             outPC,
  output logic [XLEN-1:0]             outPredPC,
  output logic                        outPredTaken,
  output logic [INDEX-1:0]            outGHRIndex,
  output logic [1:0]                  outPHTState,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pred_pc;
    logic             taken;
    logic [INDEX-1:0] ghr;
    logic [1:0]       pht;
  } entry_t;

  // Fetch PC
  logic [XLEN-1:0]  pc_q;

  // Response stage: metadata of the request whose data arrives this cycle
  logic             resp_valid;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  resp_pred_pc;
  logic             resp_taken;
  logic [INDEX-1:0] resp_ghr;
  logic [1:0]       resp_pht;

  // Queue
  entry_t           mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_q;

  // Datapath / control
  logic [CW:0]      credit_used;
  logic             issue;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_pc;
  logic             enq;
  logic             deq;
  logic             head_valid;
  entry_t           wr_entry;
  entry_t           head_entry;

  // ---------------------------------------------------------------------------
  // Issue and prediction
  // ---------------------------------------------------------------------------

  // The in-flight response is counted against the queue so it always has a
  // free slot when its data returns; a dequeue in the same cycle gives no credit.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, resp_valid};
  assign issue       = !flush && !freeze && (credit_used < CW1'(DEPTH));

  assign pred_taken  = btbHit & phtState[1];
  assign pred_pc     = pred_taken ? btbTarget : (pc_q + XLEN'(4));

  assign imemReq     = issue;
  assign imemAddr    = pc_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc_q <= RESET_PC;
    end else if (flush) begin
      pc_q <= flushPC;
    end else if (issue) begin
      pc_q <= pred_pc;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      resp_valid   <= 1'b0;
      resp_pc      <= '0;
      resp_pred_pc <= '0;
      resp_taken   <= 1'b0;
      resp_ghr     <= '0;
      resp_pht     <= '0;
    end else begin
      // Clearing on flush squashes the response already on its way back.
      resp_valid <= issue;
      if (issue) begin
        resp_pc      <= pc_q;
        resp_pred_pc <= pred_pc;
        resp_taken   <= pred_taken;
        resp_ghr     <= ghrIndex;
        resp_pht     <= phtState;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Queue
  // ---------------------------------------------------------------------------

  assign head_valid = (count_q != '0);
  assign enq        = resp_valid && !flush;
  assign deq        = outValid && outReady;

  always_comb begin
    wr_entry         = '0;
    wr_entry.instr   = imemData;
    wr_entry.pc      = resp_pc;
    wr_entry.pred_pc = resp_pred_pc;
    wr_entry.taken   = resp_taken;
    wr_entry.ghr     = resp_ghr;
    wr_entry.pht     = resp_pht;
  end

  // Storage needs no reset: nothing is observable until count says so.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs
  // ---------------------------------------------------------------------------

  assign head_entry   = mem[head];

  // A redirect hides the head so decode cannot take a stale entry.
  assign outValid     = head_valid && !flush;
  assign outInstr     = head_entry.instr;
  assign outPC        = head_entry.pc;
  assign outPredPC    = head_entry.pred_pc;
  assign outPredTaken = head_entry.taken;
  assign outGHRIndex  = head_entry.ghr;
  assign outPHTState  = head_entry.pht;
  assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: synchronous-read instruction memory, a small BTB/PHT stub,
// and a cycle model whose issued fetches are pushed to a scoreboard and popped on dequeue.
module tb_fetch_queue_unit;

  localparam int              XLEN     = 32;
  localparam int              DEPTH    = 4;
  localparam int              INDEX    = 8;
  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  logic             clk = 1'b0;
  logic             resetN = 1'b1;
  logic             flush = 1'b0;
  logic [XLEN-1:0]  flushPC = '0;
  logic             freeze = 1'b0;
  logic             imemReq;
  logic [XLEN-1:0]  imemAddr;
  logic [XLEN-1:0]  imemData;
  logic             btbHit;
  logic [XLEN-1:0]  btbTarget;
  logic [1:0]       phtState;
  logic [INDEX-1:0] ghrIndex;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [XLEN-1:0]  outInstr;
  logic [XLEN-1:0]  outPC;
  logic [XLEN-1:0]  outPredPC;
  logic             outPredTaken;
  logic [INDEX-1:0] outGHRIndex;
  logic [1:0]       outPHTState;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .INDEX(INDEX), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .resetN(resetN), .flush(flush), .flushPC(flushPC), .freeze(freeze),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemData(imemData),
    .btbHit(btbHit), .btbTarget(btbTarget), .phtState(phtState), .ghrIndex(ghrIndex),
    .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outPC(outPC),
    .outPredPC(outPredPC), .outPredTaken(outPredTaken), .outGHRIndex(outGHRIndex),
    .outPHTState(outPHTState), .count(count)
  );

  // ---------------- environment: memory and predictor stub ----------------
  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  function automatic logic [INDEX-1:0] ghr_of(input logic [XLEN-1:0] a);
    return a[9:2] ^ 8'h3C;
  endfunction

  logic [XLEN-1:0] rd_addr = '0;
  always @(posedge clk) if (imemReq) rd_addr <= imemAddr;
  assign imemData = instr_of(rd_addr);

  logic             btb_en  = 1'b0;
  logic [XLEN-1:0]  btb_pc  = '0;
  logic [XLEN-1:0]  btb_tgt = '0;
  logic [1:0]       pht_cfg = 2'b00;
  assign btbHit    = btb_en && (imemAddr == btb_pc);
  assign btbTarget = btb_tgt;
  assign phtState  = pht_cfg;
  assign ghrIndex  = ghr_of(imemAddr);

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pred_pc;
    logic             taken;
    logic [INDEX-1:0] ghr;
    logic [1:0]       pht;
  } exp_t;

  exp_t            sb[$];     // issued fetches, oldest first (last one may still be in flight)
  logic [XLEN-1:0] m_pc   = RESET_PC;
  logic            m_resp = 1'b0;

  // Inputs change only just after a rising edge, so the falling edge sees the
  // values the DUT will act on at the next rising edge.
  always @(negedge clk) begin
    int              m_cnt;
    logic            exp_req;
    logic            exp_vld;
    logic            tk;
    logic [XLEN-1:0] pp;
    exp_t            e;
    if (!resetN) begin
      sb.delete();
      m_resp = 1'b0;
      m_pc   = RESET_PC;
    end else begin
      m_cnt   = sb.size() - int'(m_resp);
      exp_req = !flush && !freeze && ((m_cnt + int'(m_resp)) < DEPTH);
      exp_vld = (m_cnt > 0) && !flush;
      chk("imem_addr", 64'(imemAddr), 64'(m_pc));
      chk("imem_req",  64'(imemReq),  64'(exp_req));
      chk("out_valid", 64'(outValid), 64'(exp_vld));
      chk("count",     64'(count),    64'(m_cnt));
      if (exp_vld && outReady && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_pc",      64'(outPC),        64'(e.pc));
        chk("out_instr",   64'(outInstr),     64'(e.instr));
        chk("out_pred_pc", 64'(outPredPC),    64'(e.pred_pc));
        chk("out_taken",   64'(outPredTaken), 64'(e.taken));
        chk("out_ghr",     64'(outGHRIndex),  64'(e.ghr));
        chk("out_pht",     64'(outPHTState),  64'(e.pht));
      end
      if (flush) begin
        sb.delete();
        m_resp = 1'b0;
        m_pc   = flushPC;
      end else begin
        if (exp_req) begin
          tk = btb_en && (m_pc == btb_pc) && pht_cfg[1];
          pp = tk ? btb_tgt : m_pc + 32'd4;
          e.instr   = instr_of(m_pc);
          e.pc      = m_pc;
          e.pred_pc = pp;
          e.taken   = tk;
          e.ghr     = ghr_of(m_pc);
          e.pht     = pht_cfg;
          sb.push_back(e);
          m_pc = pp;
        end
        m_resp = exp_req;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [XLEN-1:0] target);
    flushPC = target;
    flush   = 1'b1;
    step(1);
    flush   = 1'b0;
  endtask

  initial begin
    int n;
    #1 resetN = 1'b0;
    #1;
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_pc",    64'(imemAddr), 64'(RESET_PC));
    step(3);
    resetN   = 1'b1;
    outReady = 1'b1;
    step(12);                                   // free run

    outReady = 1'b0;                            // back-pressure until full
    step(10);
    chk("full_count", 64'(count),   64'(DEPTH));
    chk("full_req",   64'(imemReq), 64'd0);
    outReady = 1'b1;
    step(8);

    btb_en = 1'b1; btb_pc = 32'h8; btb_tgt = 32'h100; pht_cfg = 2'b10;
    do_flush(32'h0);                            // flush with outReady=1 and entries queued
    chk("flush_drop", 64'(count), 64'd0);
    step(10);
    pht_cfg = 2'b01;                            // hit but weakly not-taken
    do_flush(32'h0);
    step(10);
    btb_en = 1'b0;

    outReady = 1'b0;                            // 3 queued + 1 in flight, then redirect
    do_flush(32'h40);
    n = 0;
    while (count != 3 && n < 20) begin step(1); n++; end
    chk("fill3_bound", 64'(n < 20), 64'd1);
    do_flush(32'h200);
    chk("flush_count", 64'(count),    64'd0);
    chk("flush_valid", 64'(outValid), 64'd0);
    outReady = 1'b1;
    step(8);

    freeze = 1'b1;                              // freeze mid-stream
    step(5);
    freeze = 1'b0;
    step(6);
    freeze = 1'b1;                              // redirect while frozen
    do_flush(32'h300);
    step(2);
    freeze = 1'b0;
    step(6);

    do_flush(32'hFFFF_FFFC);                    // PC wrap-around
    step(6);

    step(2);                                    // reset mid-stream
    resetN = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(outValid), 64'd0);
    chk("mid_rst_count", 64'(count),    64'd0);
    chk("mid_rst_pc",    64'(imemAddr), 64'(RESET_PC));
    step(2);
    resetN = 1'b1;
    step(8);

    repeat (300) begin                          // random mix
      outReady = ($urandom_range(0, 3) != 0);
      freeze   = ($urandom_range(0, 7) == 0);
      btb_en   = ($urandom_range(0, 1) == 1);
      btb_pc   = 32'($urandom_range(0, 15)) << 2;
      btb_tgt  = 32'($urandom_range(0, 15)) << 2;
      pht_cfg  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        flush   = 1'b1;
        flushPC = 32'($urandom_range(0, 63)) << 2;
      end else begin
        flush   = 1'b0;
      end
      step(1);
    end
    flush = 1'b0; freeze = 1'b0; outReady = 1'b1; btb_en = 1'b0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
